prod_accum: RTL and testbench

//   Downstream consumer of the sequential multiplier's registered 2N-bit product.

---
 rtl/mult_pkg.sv | 17 +
 rtl/accum_sat_add.sv | 29 ++
 rtl/prod_accum.sv | 108 ++++++++++
 tb/tb_prod_accum.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and default widths for the product accumulator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_pkg;

    localparam int DEF_N     = 32;
    localparam int DEF_G     = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_AW    = 2 * DEF_N + DEF_G;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/accum_sat_add.sv
// Combinational AW-bit accumulator adder: acc + zero-extended product, with carry-out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none. PROD_ACCUM_SATURATE_EN clamps the sum to all-ones on carry.
module accum_sat_add #(
    parameter int AW = 72,
    parameter int PW = 64
) (
    input  logic [AW-1:0] acc,
    input  logic [PW-1:0] addend,
    output logic [AW-1:0] sum,
    output logic          carry
);

    logic [AW:0] wide;

    // Sum at AW+1 bits; the top bit is the overflow indication.
    always_comb begin
        wide  = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, addend};
        carry = wide[AW];
`ifdef PROD_ACCUM_SATURATE_EN
        // Once the carry fires the result pins at all-ones; adding further
        // products to all-ones carries again, so it stays pinned.
        sum   = wide[AW] ? {AW{1'b1}} : wide[AW-1:0];
`else
        sum   = wide[AW-1:0];
`endif
    end

endmodule

// File: rtl/prod_accum.sv
// Sums a burst of len unsigned products into an AW-bit accumulator with sticky overflow.
// Latency: acc updates the cycle after each accept; out_valid the cycle after the last accept.
// Backpressure: in_ready only in ACC; result held in DONE until out_ready (PROD_ACCUM_SATURATE_EN selects clamp).
module prod_accum
    import mult_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int G     = DEF_G,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*N-1:0]       product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*N+G-1:0]     acc_out,
    output logic                 overflow,
    output logic                 busy
);

    localparam int AW = 2 * N + G;
    localparam int PW = 2 * N;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    logic [AW-1:0]    add_sum;
    logic             add_carry;

    accum_sat_add #(
        .AW (AW),
        .PW (PW)
    ) u_add (
        .acc    (acc_q),
        .addend (product),
        .sum    (add_sum),
        .carry  (add_carry)
    );

    // Next-state and datapath updates; start only matters in IDLE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    len_d   = len;
                    state_d = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_carry;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == (len_q - CNT_ONE)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any burst in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode registered state only; no path from in_valid.
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum at N=4, G=1 (AW=9) so overflow is easy to reach.
// Latency: n/a.
// Backpressure: exercised via gapped in_valid and delayed out_ready.
module tb_prod_accum;

    localparam int N     = 4;
    localparam int G     = 1;
    localparam int CNT_W = 8;
    localparam int AW    = 2 * N + G;
    localparam int AMAX  = (1 << AW) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2*N-1:0]   product = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [AW-1:0]    acc_out;
    logic             overflow;
    logic             busy;

    int errors = 0;
    int checks = 0;

    int prod_tab [32];
    int gap_tab  [32];

    prod_accum #(.N(N), .G(G), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int n);
        start = 1'b1;
        len   = CNT_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Offers n products from prod_tab with gap_tab idle cycles before each;
    // stalls counts cycles spent waiting for in_ready (bounded per product).
    task automatic feed(input int n, output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap_tab[i]; g++) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            product  = (2*N)'(prod_tab[i]);
            w = 0;
            while (!in_ready && w < 8) begin
                tick();
                w++;
                stalls++;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Reference: plain integer sum of the burst, then wrap or clamp.
    function automatic int model_total(input int n);
        int t = 0;
        for (int i = 0; i < n; i++) t += prod_tab[i];
        return t;
    endfunction

    function automatic int model_acc(input int n);
        int t = model_total(n);
`ifdef PROD_ACCUM_SATURATE_EN
        return (t > AMAX) ? AMAX : t;
`else
        return t % (AMAX + 1);
`endif
    endfunction

    function automatic logic model_ovf(input int n);
        return model_total(n) > AMAX;
    endfunction

    task automatic test_reset();
        checks++; if (acc_out !== '0) begin errors++; $display("FAIL reset_acc: got %0d want 0", acc_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid_burst();
        int st;
        prod_tab[0] = 3; prod_tab[1] = 4;
        gap_tab[0] = 0;  gap_tab[1] = 0;
        kick(5);
        feed(2, st);
        checks++; if (acc_out !== 9'd7) begin errors++; $display("FAIL mid_partial_acc: got %0d want 7", acc_out); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (acc_out !== '0) begin errors++; $display("FAIL mid_reset_acc: got %0d want 0", acc_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_in_ready: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        prod_tab[0] = 11;
        kick(1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_restart_in_ready: got %b want 1", in_ready); end
        feed(1, st);
        checks++; if (acc_out !== 9'd11) begin errors++; $display("FAIL mid_restart_acc: got %0d want 11", acc_out); end
        release_out();
    endtask

    task automatic test_back_to_back();
        int st;
        prod_tab[0] = 5; prod_tab[1] = 7; prod_tab[2] = 9;
        for (int i = 0; i < 3; i++) gap_tab[i] = 0;
        kick(3);
        feed(3, st);
        checks++; if (st !== 0) begin errors++; $display("FAIL b2b_stalls: got %0d want 0", st); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid: got %b want 1", out_valid); end
        checks++; if (acc_out !== 9'd21) begin errors++; $display("FAIL b2b_acc: got %0d want 21", acc_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_done: got %b want 0", in_ready); end
        release_out();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_released: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        int st;
        int exp_acc;
        for (int i = 0; i < 3; i++) begin prod_tab[i] = 255; gap_tab[i] = 0; end
`ifdef PROD_ACCUM_SATURATE_EN
        exp_acc = 511;
`else
        exp_acc = 253;
`endif
        kick(3);
        feed(3, st);
        checks++; if (acc_out !== AW'(exp_acc)) begin errors++; $display("FAIL ovf_acc: got %0d want %0d", acc_out, exp_acc); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        release_out();
    endtask

    task automatic test_zero_len();
        in_valid = 1'b1;
        product  = 8'd50;
        kick(0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zlen_out_valid: got %b want 1", out_valid); end
        checks++; if (acc_out !== '0) begin errors++; $display("FAIL zlen_acc: got %0d want 0", acc_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL zlen_overflow_cleared: got %b want 0", overflow); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zlen_in_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (acc_out !== '0) begin errors++; $display("FAIL zlen_no_accept: got %0d want 0", acc_out); end
        in_valid = 1'b0;
        release_out();
    endtask

    task automatic test_hold();
        int st;
        prod_tab[0] = 100; prod_tab[1] = 20;
        gap_tab[0] = 0;    gap_tab[1] = 0;
        kick(2);
        feed(2, st);
        for (int c = 0; c < 10; c++) begin
            start = 1'b1;
            len   = 8'd3;
            checks++; if (acc_out !== 9'd120) begin errors++; $display("FAIL hold_acc[%0d]: got %0d want 120", c, acc_out); end
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL hold_hs[%0d]: in_ready=%b out_valid=%b want 0/1", c, in_ready, out_valid); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_start_ignored: busy=%b want 0", busy); end
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL hold_idle: in_ready=%b out_valid=%b want 0/0", in_ready, out_valid); end
    endtask

    task automatic test_gapped();
        int st;
        prod_tab[0] = 1; prod_tab[1] = 2; prod_tab[2] = 3;
        gap_tab[0] = 0;  gap_tab[1] = 2; gap_tab[2] = 0;
        kick(3);
        feed(3, st);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_out_valid: got %b want 1", out_valid); end
        checks++; if (acc_out !== 9'd6) begin errors++; $display("FAIL gap_acc: got %0d want 6", acc_out); end
        release_out();
    endtask

    task automatic test_random();
        int st;
        int n;
        int dly;
        for (int b = 0; b < 25; b++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                prod_tab[i] = $urandom_range(0, 255);
                gap_tab[i]  = $urandom_range(0, 2);
            end
            kick(n);
            feed(n, st);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rnd_out_valid[%0d]: got %b want 1", b, out_valid); end
            checks++; if (acc_out !== AW'(model_acc(n))) begin errors++; $display("FAIL rnd_acc[%0d]: got %0d want %0d", b, acc_out, model_acc(n)); end
            checks++; if (overflow !== model_ovf(n)) begin errors++; $display("FAIL rnd_ovf[%0d]: got %b want %b", b, overflow, model_ovf(n)); end
            dly = $urandom_range(0, 3);
            for (int d = 0; d < dly; d++) tick();
            checks++; if (acc_out !== AW'(model_acc(n))) begin errors++; $display("FAIL rnd_hold[%0d]: got %0d want %0d", b, acc_out, model_acc(n)); end
            release_out();
        end
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_reset_mid_burst();
        test_back_to_back();
        test_overflow();
        test_zero_len();
        test_hold();
        test_gapped();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
